uart_wb_master: RTL and testbench

- Wishbone initiator driven by a byte-serial command stream from a UART core; the debug/loader path into the 16-bit system bus.
- Consumes command bytes from the UART receive side, runs single 16-bit Wishbone read/write cycles, and returns response bytes through the UART transmit side.
- Sits between the uart core instance and the bus interconnect as a bus master, the counterpart of the bus-slave UART wrappers.

---
 rtl/uart_wb_master.sv | 185 ++++++++++++++++++
 tb/tb_uart_wb_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// Wishbone initiator driven by a byte-serial command stream from a UART core.
// 'R' A3..A0 reads 16 bits; 'W' A3..A0 D1 D0 writes; the reply is data, 'K' or 'E'.
module uart_wb_master #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic        rx_rd_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  input  logic        tx_busy_i,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, TXW} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          rx_rd_q, rx_rd_d;
  logic          rx_gap_q, rx_gap_d;
  logic          tx_wr_q, tx_wr_d;
  logic          rx_state;
  logic [7:0]    resp_byte;

  assign rx_state = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);

  // cnt_q holds the number of response bytes still to send while in RESP/TXW
  always_comb begin
    resp_byte = 8'h4B;
    if (err_q)
      resp_byte = 8'h45;
    else if (!we_q)
      resp_byte = (cnt_q == 2'd2) ? rdata_q[15:8] : rdata_q[7:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    tx_wr_d   = 1'b0;
    rx_gap_d  = rx_rd_q;
    // The cycle after a read strobe is skipped so the core can drop rx_ready_i.
    rx_rd_d   = rx_state && rx_ready_i && !rx_rd_q && !rx_gap_q;

    case (state_q)
      IDLE: begin
        if (rx_rd_q) begin
          cnt_d = 2'd0;
          if (rx_data_i == 8'h52) begin
            we_d    = 1'b0;
            state_d = ADDR;
          end else if (rx_data_i == 8'h57) begin
            we_d    = 1'b1;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (rx_rd_q) begin
          adr_d = {adr_q[23:0], rx_data_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              cyc_d   = 1'b1;
              tmo_d   = '0;
            end
          end
        end
      end
      DATA: begin
        if (rx_rd_q) begin
          dat_d = {dat_q[7:0], rx_data_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = BUS;
            cyc_d   = 1'b1;
            tmo_d   = '0;
          end
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = we_q ? 2'd1 : 2'd2;
          state_d = RESP;
          if (!we_q)
            rdata_d = wb_dat_i;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 2'd1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        tx_data_d = resp_byte;
        if (!tx_busy_i) begin
          tx_wr_d = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          state_d = TXW;
        end
      end
      TXW: begin
        state_d = (cnt_q == 2'd0) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata_q   <= '0;
      tx_data_q <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      err_q     <= 1'b0;
      rx_rd_q   <= 1'b0;
      rx_gap_q  <= 1'b0;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      rx_rd_q   <= rx_rd_d;
      rx_gap_q  <= rx_gap_d;
      tx_wr_q   <= tx_wr_d;
    end
  end

  assign rx_rd_o   = rx_rd_q;
  assign tx_data_o = tx_data_q;
  assign tx_wr_o   = tx_wr_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = cyc_q & we_q;
  assign wb_sel_o  = {2{cyc_q}};
endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: UART/Wishbone slave models plus an
// expectation queue of bus cycles and response bytes derived from each frame.
module tb_uart_wb_master;
  localparam int TIMEOUT  = 1024;
  localparam int BUSY_LEN = 12;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_i;
  logic        rx_rd_o;
  logic [7:0]  tx_data_o;
  logic        tx_wr_o;
  logic        tx_busy_i;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  uart_wb_master #(.TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .rx_rd_o(rx_rd_o),
    .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o), .tx_busy_i(tx_busy_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    int          delay;   // ack arrives in this cycle of the bus cycle; <0 never
  } bus_t;
  typedef struct {
    int          delay;
    logic [15:0] rdata;
  } plan_t;

  bus_t       exp_bus[$];
  plan_t      plan[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];

  int          n_pass = 0;
  int          n_total = 0;
  int          n_bus = 0;
  int          last_len = 0;
  logic [31:0] last_adr = '0;
  logic [15:0] last_dat = '0;
  logic        last_we = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic feed(input logic [63:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) rx_q.push_back(bytes[8*i +: 8]);
  endtask

  // Expected outcome of one frame: bus cycle, slave behaviour, reply bytes.
  task automatic exp_frame(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                           input int delay, input logic [15:0] rdata);
    bus_t  b;
    plan_t p;
    b.we = we; b.adr = adr; b.dat = dat; b.delay = delay;
    p.delay = delay; p.rdata = rdata;
    exp_bus.push_back(b);
    plan.push_back(p);
    if (delay < 0) exp_tx.push_back(8'h45);
    else if (we) exp_tx.push_back(8'h4B);
    else begin
      exp_tx.push_back(rdata[15:8]);
      exp_tx.push_back(rdata[7:0]);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (exp_tx.size() == 0 && rx_q.size() == 0 && !wb_cyc_o && !tx_busy_i) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  // Environment: UART core receive/transmit side and a Wishbone slave.
  initial begin
    int   k;
    int   busy_left;
    logic s_rd, s_cyc, s_wr;
    k = 0; busy_left = 0;
    rx_ready_i = 1'b0; rx_data_i = 8'h00; tx_busy_i = 1'b0;
    wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
    forever begin
      @(negedge clk_i);
      s_rd = rx_rd_o; s_cyc = wb_cyc_o; s_wr = tx_wr_o;
      @(posedge clk_i); #1;
      if (rst_i) begin
        k = 0; busy_left = 0; wb_ack_i = 1'b0; tx_busy_i = 1'b0;
      end else begin
        if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        wb_ack_i = 1'b0;
        if (s_cyc) begin
          if (plan.size() > 0 && plan[0].delay == k + 1) begin
            wb_ack_i = 1'b1;
            wb_dat_i = plan[0].rdata;
          end
          k++;
        end else if (k > 0) begin
          k = 0;
          if (plan.size() > 0) void'(plan.pop_front());
        end
        if (s_wr) busy_left = BUSY_LEN;
        else if (busy_left > 0) busy_left--;
        tx_busy_i = (busy_left > 0);
      end
      rx_ready_i = (rx_q.size() > 0);
      rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Compare process: checks DUT outputs against the expectation queues each cycle.
  initial begin
    bus_t cur;
    int   cyc_len;
    logic prev_cyc, prev_rd, prev_wr, prev_busy;
    logic [7:0] t;
    cur.we = 1'b0; cur.adr = '0; cur.dat = '0; cur.delay = 0;
    cyc_len = 0; prev_cyc = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        cyc_len = 0; prev_cyc = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_busy = 1'b0;
        continue;
      end
      chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      chk("sel", wb_sel_o, wb_cyc_o ? 2'b11 : 2'b00);
      if (wb_cyc_o && !prev_cyc) begin
        if (exp_bus.size() == 0) begin
          chk("bus_expected", 1'b0, 1'b1);
          cur.we = wb_we_o; cur.adr = wb_adr_o; cur.dat = wb_dat_o; cur.delay = 0;
        end else begin
          cur = exp_bus.pop_front();
          chk("bus_adr", wb_adr_o, cur.adr);
          chk("bus_we", wb_we_o, cur.we);
          if (cur.we) chk("bus_dat", wb_dat_o, cur.dat);
        end
        last_adr = wb_adr_o; last_dat = wb_dat_o; last_we = wb_we_o;
        cyc_len = 1;
        n_bus++;
      end else if (wb_cyc_o) begin
        cyc_len++;
        chk("adr_hold", wb_adr_o, cur.adr);
        chk("we_hold", wb_we_o, cur.we);
        if (cur.we) chk("dat_hold", wb_dat_o, cur.dat);
      end
      if (!wb_cyc_o && prev_cyc) begin
        chk("cyc_len", cyc_len, (cur.delay < 0) ? TIMEOUT : cur.delay + 1);
        last_len = cyc_len;
      end
      if (!wb_cyc_o) chk("we_idle", wb_we_o, 1'b0);
      if (rx_rd_o) begin
        chk("rd_gap", prev_rd, 1'b0);
        chk("rd_no_bus", wb_cyc_o, 1'b0);
      end
      if (tx_wr_o) begin
        chk("wr_gap", prev_wr, 1'b0);
        chk("wr_after_busy_low", prev_busy, 1'b0);
        if (exp_tx.size() == 0) chk("tx_expected", 1'b0, 1'b1);
        else begin
          t = exp_tx.pop_front();
          chk("tx_byte", tx_data_o, t);
        end
        tx_log.push_back(tx_data_o);
        $display("tx byte %h", tx_data_o);
      end
      prev_cyc = wb_cyc_o; prev_rd = rx_rd_o; prev_wr = tx_wr_o; prev_busy = tx_busy_i;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int nk;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_rd", rx_rd_o, 1'b0);
    chk("rst_wr", tx_wr_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_txd", tx_data_o, 8'h0);
    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Write with ack one cycle after strobe
    exp_frame(1'b1, 32'h0000_1004, 16'hBEEF, 1, 16'h0);
    feed(64'h57_00_00_10_04_BE_EF, 7);
    wait_done("write_done", 300);
    $display("write: adr %h dat %h len %0d", last_adr, last_dat, last_len);
    chk("write_adr_lit", last_adr, 32'h0000_1004);
    chk("write_dat_lit", last_dat, 16'hBEEF);
    chk("write_we_lit", last_we, 1'b1);
    chk("write_len_lit", last_len, 2);
    chk("write_resp_lit", tx_log[tx_log.size() - 1], 8'h4B);

    // Read with three wait cycles
    exp_frame(1'b0, 32'h0000_0004, 16'h0, 3, 16'h1234);
    feed(64'h52_00_00_00_04, 5);
    wait_done("read_done", 300);
    $display("read: adr %h len %0d", last_adr, last_len);
    chk("read_adr_lit", last_adr, 32'h0000_0004);
    chk("read_len_lit", last_len, 4);
    chk("read_hi_lit", tx_log[tx_log.size() - 2], 8'h12);
    chk("read_lo_lit", tx_log[tx_log.size() - 1], 8'h34);

    // Timeout, then a normal write
    exp_frame(1'b0, 32'h0000_0040, 16'h0, -1, 16'h0);
    feed(64'h52_00_00_00_40, 5);
    wait_done("timeout_done", 3000);
    $display("timeout: len %0d", last_len);
    chk("timeout_len_lit", last_len, TIMEOUT);
    chk("timeout_resp_lit", tx_log[tx_log.size() - 1], 8'h45);
    exp_frame(1'b1, 32'h0000_0020, 16'h5555, 2, 16'h0);
    feed(64'h57_00_00_00_20_55_55, 7);
    wait_done("after_timeout_done", 300);
    chk("after_timeout_resp_lit", tx_log[tx_log.size() - 1], 8'h4B);

    // Garbage bytes ahead of a read
    b0 = n_bus;
    exp_frame(1'b0, 32'h0000_0002, 16'h0, 1, 16'hA55A);
    feed(64'h00_FF_52_00_00_00_02, 7);
    wait_done("garbage_done", 300);
    $display("garbage: bus cycles %0d adr %h", n_bus - b0, last_adr);
    chk("garbage_bus_count", n_bus - b0, 1);
    chk("garbage_adr_lit", last_adr, 32'h0000_0002);

    // Asynchronous reset in the middle of a bus cycle
    exp_frame(1'b0, 32'h0000_0008, 16'h0, -1, 16'h0);
    feed(64'h52_00_00_00_08, 5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (wb_cyc_o) break;
    end
    chk("rst_mid_cyc_seen", wb_cyc_o, 1'b1);
    repeat (5) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    $display("mid-cycle reset: cyc %b stb %b we %b", wb_cyc_o, wb_stb_o, wb_we_o);
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_we", wb_we_o, 1'b0);
    chk("arst_wr", tx_wr_o, 1'b0);
    chk("arst_rd", rx_rd_o, 1'b0);
    chk("arst_adr", wb_adr_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    exp_tx.delete(); plan.delete(); exp_bus.delete(); rx_q.delete();
    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    exp_frame(1'b1, 32'hCAFE_0000, 16'h0123, 1, 16'h0);
    feed(64'h57_CA_FE_00_00_01_23, 7);
    wait_done("post_reset_done", 300);
    chk("post_reset_adr_lit", last_adr, 32'hCAFE_0000);
    chk("post_reset_resp_lit", tx_log[tx_log.size() - 1], 8'h4B);

    // Two write frames back to back, rx_ready_i held high throughout
    b0 = n_bus;
    exp_frame(1'b1, 32'h0000_0100, 16'h1111, 1, 16'h0);
    exp_frame(1'b1, 32'h0000_0200, 16'h2222, 2, 16'h0);
    feed(64'h57_00_00_01_00_11_11, 7);
    feed(64'h57_00_00_02_00_22_22, 7);
    wait_done("b2b_done", 600);
    nk = 0;
    if (tx_log[tx_log.size() - 1] == 8'h4B) nk++;
    if (tx_log[tx_log.size() - 2] == 8'h4B) nk++;
    $display("back-to-back: bus cycles %0d K replies %0d", n_bus - b0, nk);
    chk("b2b_bus_count", n_bus - b0, 2);
    chk("b2b_k_count", nk, 2);
    chk("b2b_last_adr_lit", last_adr, 32'h0000_0200);

    chk("exp_bus_empty", exp_bus.size(), 0);
    chk("exp_tx_empty", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
